// File: rtl/lq_multifill_if.sv
// Load-queue port bundle: enqueue, fill channels, branch resolve, dequeue and occupancy.
// The master side drives loads, fills, branch outcomes and deq_ready; the slave side is the queue.
interface lq_multifill_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 6,
    parameter int FILL_PORTS = 2,
    parameter int BR_MASK_W  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                         enq_valid;
    logic                         enq_ready;
    logic [ADDR_W-1:0]            enq_addr;
    logic [TAG_W-1:0]             enq_dest;
    logic [BR_MASK_W-1:0]         enq_br_mask;
    logic [FILL_PORTS-1:0]        fill_valid;
    logic [FILL_PORTS*ADDR_W-1:0] fill_addr;
    logic [FILL_PORTS*DATA_W-1:0] fill_data;
    logic                         br_valid;
    logic                         br_mispredict;
    logic [BR_MASK_W-1:0]         br_bit;
    logic                         deq_ready;
    logic                         deq_valid;
    logic [ADDR_W-1:0]            deq_addr;
    logic [DATA_W-1:0]            deq_data;
    logic [TAG_W-1:0]             deq_dest;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         empty;

    modport master (
        output enq_valid, enq_addr, enq_dest, enq_br_mask,
        output fill_valid, fill_addr, fill_data,
        output br_valid, br_mispredict, br_bit, deq_ready,
        input  enq_ready, deq_valid, deq_addr, deq_data, deq_dest, count, full, empty
    );

    modport slave (
        input  enq_valid, enq_addr, enq_dest, enq_br_mask,
        input  fill_valid, fill_addr, fill_data,
        input  br_valid, br_mispredict, br_bit, deq_ready,
        output enq_ready, deq_valid, deq_addr, deq_data, deq_dest, count, full, empty
    );
endinterface

// File: rtl/lq_multifill.sv
// In-order load queue with multi-port fill capture and branch-mask selective squash; a fill at edge N gives deq_valid in cycle N+1.
// Backpressure: enq_ready drops when full or on a mispredict; the head is held until deq_ready.
module lq_multifill #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 6,
    parameter int FILL_PORTS = 2,
    parameter int MATCH_LSB  = 3,
    parameter int BR_MASK_W  = 4
) (
    input logic           clock,
    input logic           reset,
    lq_multifill_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] MATCH_MASK = ~(ADDR_W'((64'd1 << MATCH_LSB) - 64'd1));

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     data_valid_q;
    logic [ADDR_W-1:0]    addr_q    [DEPTH];
    logic [TAG_W-1:0]     dest_q    [DEPTH];
    logic [DATA_W-1:0]    data_q    [DEPTH];
    logic [BR_MASK_W-1:0] br_mask_q [DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 mispredict;
    logic [BR_MASK_W-1:0] clear_mask;
    logic                 enq_fire;
    logic                 deq_fire;
    logic [DEPTH-1:0]     squash;
    logic [CNT_W-1:0]     squash_cnt;
    logic [DEPTH-1:0]     fill_hit;
    logic [DATA_W-1:0]    fill_sel  [DEPTH];
    logic [ADDR_W-1:0]    cmp_addr  [DEPTH];

    assign mispredict = bus.br_valid & bus.br_mispredict;
    assign clear_mask = (bus.br_valid & ~bus.br_mispredict) ? bus.br_bit : '0;

    assign bus.count     = count_q;
    assign bus.full      = (count_q == CNT_W'(DEPTH));
    assign bus.empty     = (count_q == '0);
    assign bus.enq_ready = ~bus.full & ~mispredict;
    assign enq_fire      = bus.enq_valid & bus.enq_ready;

    // A head that is about to be squashed must not be handed to writeback.
    assign bus.deq_valid = valid_q[head_q] & data_valid_q[head_q]
                         & ~(mispredict & |(br_mask_q[head_q] & bus.br_bit));
    assign bus.deq_addr  = addr_q[head_q];
    assign bus.deq_data  = data_q[head_q];
    assign bus.deq_dest  = dest_q[head_q];
    assign deq_fire      = bus.deq_valid & bus.deq_ready;

    always_comb begin
        squash_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i]   = mispredict & valid_q[i] & |(br_mask_q[i] & bus.br_bit);
            squash_cnt  = squash_cnt + CNT_W'(squash[i]);
            // The slot being written this cycle compares the incoming address.
            cmp_addr[i] = (enq_fire && tail_q == PTR_W'(i)) ? bus.enq_addr : addr_q[i];
            fill_hit[i] = 1'b0;
            fill_sel[i] = '0;
            // Descending scan so the lowest matching port is the last writer.
            for (int p = FILL_PORTS - 1; p >= 0; p--) begin
                if (bus.fill_valid[p] &&
                    ((cmp_addr[i] ^ bus.fill_addr[p*ADDR_W +: ADDR_W]) & MATCH_MASK) == '0) begin
                    fill_hit[i] = 1'b1;
                    fill_sel[i] = bus.fill_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            data_valid_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i] || (deq_fire && head_q == PTR_W'(i))) begin
                    valid_q[i]      <= 1'b0;
                    data_valid_q[i] <= 1'b0;
                end else if (enq_fire && tail_q == PTR_W'(i)) begin
                    valid_q[i]      <= 1'b1;
                    addr_q[i]       <= bus.enq_addr;
                    dest_q[i]       <= bus.enq_dest;
                    br_mask_q[i]    <= bus.enq_br_mask & ~clear_mask;
                    data_valid_q[i] <= fill_hit[i];
                    data_q[i]       <= fill_sel[i];
                end else if (valid_q[i]) begin
                    br_mask_q[i] <= br_mask_q[i] & ~clear_mask;
                    if (!data_valid_q[i] && fill_hit[i]) begin
                        data_valid_q[i] <= 1'b1;
                        data_q[i]       <= fill_sel[i];
                    end
                end
            end
            if (deq_fire) begin
                head_q <= head_q + PTR_W'(1);
            end
            // Squashed entries are the youngest, so the tail simply backs up over them.
            if (squash_cnt != '0) begin
                tail_q <= tail_q - PTR_W'(squash_cnt);
            end else if (enq_fire) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire) - squash_cnt;
        end
    end

    br_bit_onehot: assert property (@(posedge clock) disable iff (reset)
        bus.br_valid |-> $onehot(bus.br_bit));
endmodule

// File: tb/tb_lq_multifill.sv
// Directed and randomized bench for lq_multifill against a queue-based reference model.
module tb_lq_multifill;
    localparam int DEPTH = 8, ADDR_W = 64, DATA_W = 64, TAG_W = 6;
    localparam int FILL_PORTS = 2, MATCH_LSB = 3, BR_MASK_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lq_multifill_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                      .FILL_PORTS(FILL_PORTS), .BR_MASK_W(BR_MASK_W)) bus ();

    lq_multifill #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                   .FILL_PORTS(FILL_PORTS), .MATCH_LSB(MATCH_LSB), .BR_MASK_W(BR_MASK_W))
        dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [ADDR_W-1:0]    addr;
        logic [TAG_W-1:0]     dest;
        logic [DATA_W-1:0]    data;
        bit                   dv;
        logic [BR_MASK_W-1:0] mask;
    } ment_t;

    ment_t mq[$];
    int    br_order[$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit squashed(ment_t e);
        return bus.br_valid && bus.br_mispredict && ((e.mask & bus.br_bit) != '0);
    endfunction

    function automatic bit exp_enq_ready();
        return (mq.size() < DEPTH) && !(bus.br_valid && bus.br_mispredict);
    endfunction

    function automatic bit exp_deq_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].dv && !squashed(mq[0]);
    endfunction

    function automatic ment_t apply_fill(ment_t e);
        ment_t r = e;
        if (!r.dv) begin
            for (int p = 0; p < FILL_PORTS; p++) begin
                if (bus.fill_valid[p] &&
                    (r.addr >> MATCH_LSB) == (bus.fill_addr[p*ADDR_W +: ADDR_W] >> MATCH_LSB)) begin
                    r.data = bus.fill_data[p*DATA_W +: DATA_W];
                    r.dv   = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic check_all();
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("full", 64'(bus.full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
        chk("enq_ready", 64'(bus.enq_ready), 64'(exp_enq_ready()));
        chk("deq_valid", 64'(bus.deq_valid), 64'(exp_deq_valid()));
        if (exp_deq_valid()) begin
            chk("deq_addr", bus.deq_addr, mq[0].addr);
            chk("deq_data", bus.deq_data, mq[0].data);
            chk("deq_dest", 64'(bus.deq_dest), 64'(mq[0].dest));
        end
    endtask

    task automatic model_tick();
        ment_t nq[$];
        ment_t e;
        bit dfire, efire;
        logic [BR_MASK_W-1:0] clr;
        if (reset) begin
            mq.delete();
            return;
        end
        dfire = exp_deq_valid() && bus.deq_ready;
        efire = bus.enq_valid && exp_enq_ready();
        clr   = (bus.br_valid && !bus.br_mispredict) ? bus.br_bit : '0;
        foreach (mq[i]) begin
            e = mq[i];
            if (squashed(e) || (i == 0 && dfire)) continue;
            e = apply_fill(e);
            e.mask &= ~clr;
            nq.push_back(e);
        end
        if (efire) begin
            e.addr = bus.enq_addr;
            e.dest = bus.enq_dest;
            e.data = '0;
            e.dv   = 1'b0;
            e.mask = bus.enq_br_mask & ~clr;
            nq.push_back(apply_fill(e));
        end
        mq = nq;
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clock);
        model_tick();
        @(negedge clock);
    endtask

    task automatic idle();
        bus.enq_valid     = 1'b0;
        bus.enq_addr      = '0;
        bus.enq_dest      = '0;
        bus.enq_br_mask   = '0;
        bus.fill_valid    = '0;
        bus.fill_addr     = '0;
        bus.fill_data     = '0;
        bus.br_valid      = 1'b0;
        bus.br_mispredict = 1'b0;
        bus.br_bit        = '0;
        bus.deq_ready     = 1'b0;
    endtask

    task automatic enq(logic [ADDR_W-1:0] a, int d, logic [BR_MASK_W-1:0] m);
        bus.enq_valid   = 1'b1;
        bus.enq_addr    = a;
        bus.enq_dest    = TAG_W'(d);
        bus.enq_br_mask = m;
    endtask

    task automatic set_fill(int p, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        bus.fill_valid[p]                 = 1'b1;
        bus.fill_addr[p*ADDR_W +: ADDR_W] = a;
        bus.fill_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic resolve(bit mis, logic [BR_MASK_W-1:0] b);
        bus.br_valid      = 1'b1;
        bus.br_mispredict = mis;
        bus.br_bit        = b;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] pool_addr();
        return 64'h1000 + 64'(8 * $urandom_range(0, 5)) + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        int exp_d[4];
        logic [BR_MASK_W-1:0] cur_mask;
        int k;
        exp_d = '{0, 1, 2, 20};
        k = 0;

        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mq.delete();
        #1;
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);

        // Fill the queue completely
        for (int i = 0; i < 8; i++) begin
            enq(64'h100 + 64'(8 * i), i, '0);
            step();
        end
        idle();
        #1;
        chk("full8_count", 64'(bus.count), 64'd8);
        chk("full8_full", 64'(bus.full), 64'd1);
        chk("full8_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("full8_deq_valid", 64'(bus.deq_valid), 64'd0);
        step();

        set_fill(1, 64'h100, 64'hDEAD);
        step();
        idle();
        #1;
        chk("fill_deq_valid", 64'(bus.deq_valid), 64'd1);
        chk("fill_deq_data", bus.deq_data, 64'hDEAD);
        chk("fill_deq_dest", 64'(bus.deq_dest), 64'd0);
        bus.deq_ready = 1'b1;
        step();
        idle();
        #1;
        chk("deq_count", 64'(bus.count), 64'd7);

        // Both ports hit the same entry: port 0 wins
        set_fill(0, 64'h108, 64'hA);
        set_fill(1, 64'h108, 64'hB);
        step();
        idle();
        #1;
        chk("dual_fill_data", bus.deq_data, 64'hA);
        chk("dual_fill_dest", 64'(bus.deq_dest), 64'd1);
        step();

        do_reset();
        enq(64'h200, 9, '0);
        set_fill(0, 64'h200, 64'h55);
        step();
        idle();
        #1;
        chk("enq_fill_valid", 64'(bus.deq_valid), 64'd1);
        chk("enq_fill_data", bus.deq_data, 64'h55);
        step();

        // Selective squash of the youngest three
        do_reset();
        for (int i = 0; i < 6; i++) begin
            enq(64'h300 + 64'(8 * i), i, (i >= 3) ? 4'b0010 : 4'b0000);
            step();
        end
        idle();
        resolve(1'b1, 4'b0010);
        enq(64'h400, 30, '0);
        #1;
        chk("mispred_enq_ready", 64'(bus.enq_ready), 64'd0);
        step();
        idle();
        #1;
        chk("squash_count", 64'(bus.count), 64'd3);
        enq(64'h500, 20, '0);
        step();
        idle();
        set_fill(0, 64'h300, 64'h30);
        set_fill(1, 64'h308, 64'h31);
        step();
        idle();
        set_fill(0, 64'h310, 64'h32);
        set_fill(1, 64'h500, 64'h50);
        step();
        for (int i = 0; i < 4; i++) begin
            idle();
            #1;
            chk("squash_order", 64'(bus.deq_dest), 64'(exp_d[i]));
            bus.deq_ready = 1'b1;
            step();
        end

        do_reset();
        enq(64'h600, 1, 4'b0010);
        step();
        enq(64'h608, 2, 4'b0010);
        step();
        idle();
        set_fill(0, 64'h600, 64'h77);
        step();
        idle();
        #1;
        chk("pre_squash_deq_valid", 64'(bus.deq_valid), 64'd1);
        resolve(1'b1, 4'b0010);
        bus.deq_ready = 1'b1;
        #1;
        chk("head_squash_deq_valid", 64'(bus.deq_valid), 64'd0);
        step();
        idle();
        #1;
        chk("head_squash_count", 64'(bus.count), 64'd0);

        // Correct resolve clears the bit of the load written in the same cycle
        do_reset();
        enq(64'h700, 5, 4'b0001);
        resolve(1'b0, 4'b0001);
        step();
        idle();
        resolve(1'b1, 4'b0001);
        step();
        idle();
        #1;
        chk("resolve_keep_count", 64'(bus.count), 64'd1);
        set_fill(0, 64'h700, 64'h70);
        step();
        idle();
        #1;
        chk("resolve_keep_dest", 64'(bus.deq_dest), 64'd5);
        bus.deq_ready = 1'b1;
        step();

        // Randomized traffic with nested branches and one mid-stream reset
        do_reset();
        br_order.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            if (cyc == 200) begin
                reset = 1'b1;
                enq(pool_addr(), 7, '0);
                step();
                reset = 1'b0;
                br_order.delete();
                idle();
                #1;
                chk("mid_reset_empty", 64'(bus.empty), 64'd1);
                continue;
            end
            if ($urandom_range(0, 7) == 0 && br_order.size() < BR_MASK_W) begin
                for (int t = 0; t < BR_MASK_W; t++) begin
                    bit used = 1'b0;
                    foreach (br_order[j]) if (br_order[j] == t) used = 1'b1;
                    if (!used) begin
                        br_order.push_back(t);
                        break;
                    end
                end
            end
            cur_mask = '0;
            foreach (br_order[j]) cur_mask[br_order[j]] = 1'b1;
            if ($urandom_range(0, 9) < 6) enq(pool_addr(), int'($urandom_range(0, 63)), cur_mask);
            for (int p = 0; p < FILL_PORTS; p++) begin
                if ($urandom_range(0, 9) < 4) set_fill(p, pool_addr(), {$urandom, $urandom});
            end
            if (br_order.size() > 0 && $urandom_range(0, 9) == 0) begin
                k = int'($urandom_range(0, br_order.size() - 1));
                resolve(1'($urandom_range(0, 1)), BR_MASK_W'(1 << br_order[k]));
            end
            bus.deq_ready = ($urandom_range(0, 9) < 6);
            step();
            if (bus.br_valid) begin
                if (bus.br_mispredict) begin
                    while (br_order.size() > k) void'(br_order.pop_back());
                end else begin
                    br_order.delete(k);
                end
            end
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
